// File: rtl/rca_36b_pkg.sv
// Shared constants for the 36-bit ripple-carry adder.
// Holds the datapath width used by the adder and its users.
package rca_36b_pkg;

    localparam int RCA_WIDTH = 36;

endpackage

// File: rtl/rca_36b_fa_1b.sv
// One-bit full adder cell used to build the ripple chain.
// Ports: a, b, ci in; s (sum), co (carry out) out.
module fa_1b (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic p;

    // Propagate term is shared by the sum and the carry.
    assign p  = a ^ b;
    assign s  = p ^ ci;
    assign co = (a & b) | (ci & p);

endmodule

// File: rtl/rca_36b.sv
// Ripple-carry adder with registered outputs, one cycle of latency.
// Ports: clk, rst_n; S/Cout registered result; A, B, Cin operands.
module rca_36b
    import rca_36b_pkg::*;
#(
    parameter int WIDTH = RCA_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin
);

    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] s;

    assign c[0] = Cin;

    // One cell per bit; carry ripples bit 0 upward with no lookahead.
    for (genvar i = 0; i < WIDTH; i++) begin : g_chain
        fa_1b u_fa (
            .a  (A[i]),
            .b  (B[i]),
            .ci (c[i]),
            .s  (s[i]),
            .co (c[i+1])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            S    <= '0;
            Cout <= 1'b0;
        end else begin
            S    <= s;
            Cout <= c[WIDTH];
        end
    end

endmodule

// File: tb/tb_rca_36b.sv
// Directed and random checks of rca_36b against a 37-bit golden sum.
// Expected results are queued at drive time and popped one edge later.
module tb_rca_36b;

    logic        clk;
    logic        rst_n;
    logic [35:0] S;
    logic        Cout;
    logic [35:0] A;
    logic [35:0] B;
    logic        Cin;

    logic [36:0] exp_q[$];
    int          checks;
    int          failures;

    rca_36b dut (
        .clk   (clk),
        .rst_n (rst_n),
        .S     (S),
        .Cout  (Cout),
        .A     (A),
        .B     (B),
        .Cin   (Cin)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [36:0] obs,
                         input logic [36:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge: drive inputs, queue golden sum, check after edge.
    task automatic step(input string tag, input logic [35:0] a,
                        input logic [35:0] b, input logic ci);
        logic [36:0] exp;
        A   = a;
        B   = b;
        Cin = ci;
        exp_q.push_back({1'b0, a} + {1'b0, b} + {36'd0, ci});
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s: observed=empty expected=queued", tag);
        end else begin
            exp = exp_q.pop_front();
            check(tag, {Cout, S}, exp);
        end
        @(negedge clk);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        A        = 36'hF_FFFF_FFFF;
        B        = 36'hF_FFFF_FFFF;
        Cin      = 1'b1;
        #2;
        check("reset_async", {Cout, S}, 37'd0);
        @(posedge clk);
        #1;
        check("reset_held", {Cout, S}, 37'd0);
        @(negedge clk);
        rst_n = 1'b1;

        step("case1", 36'd0, 36'd0, 1'b0);
        step("case2", 36'hF_FFFF_FFFF, 36'd0, 1'b1);
        step("case3", 36'hF_FFFF_FFFF, 36'd1, 1'b0);

        // Reset between edges while a new operand set is in flight.
        A   = 36'd3;
        B   = 36'd1;
        Cin = 1'b1;
        exp_q.push_back(37'd5);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_async", {Cout, S}, 37'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        check("midreset_held", {Cout, S}, 37'd0);
        @(negedge clk);
        rst_n = 1'b1;

        step("case4", 36'd3, 36'd1, 1'b1);
        step("case5", 36'd0, 36'hF_FFFF_FFFD, 1'b1);
        step("case6", 36'd1, 36'd2, 1'b1);
        step("alt_bits", 36'hA_AAAA_AAAA, 36'h5_5555_5555, 1'b1);
        step("max_all", 36'hF_FFFF_FFFF, 36'hF_FFFF_FFFF, 1'b1);

        for (int i = 0; i < 10000; i++) begin
            step("random",
                 {4'($urandom), 32'($urandom)},
                 {4'($urandom), 32'($urandom)},
                 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
